// File: rtl/vic_pkg.sv
// ============================================================================
// Module      : vic_pkg
// Description : Shared constants, FSM state type and priority-field helper
//               for the VIC priority arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vic_pkg;

   // Index width is fixed; the all-ones code means "nothing presented"
   localparam int unsigned ADDR_W       = 5;
   localparam logic [ADDR_W-1:0] ADDR_NONE = 5'h1F;

   // Default controller geometry
   localparam int unsigned N_IRQ_DEF    = 31;
   localparam int unsigned PRIO_W_DEF   = 3;

   // Widest priority vector / field the helper function accepts
   localparam int unsigned PRIO_VEC_MAX = 256;
   localparam int unsigned PRIO_MAX_W   = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARB     = 2'd1,
      REQ     = 2'd2,
      SERVICE = 2'd3
   } vic_state_e;

   // Extract the w-bit priority field of line k from a packed vector
   function automatic logic [PRIO_MAX_W-1:0] prio_field(
      input logic [PRIO_VEC_MAX-1:0] vec,
      input int unsigned             k,
      input int unsigned             w
   );
      logic [PRIO_VEC_MAX-1:0] mask;
      logic [PRIO_VEC_MAX-1:0] sh;
      mask = (PRIO_VEC_MAX'(1) << w) - PRIO_VEC_MAX'(1);
      sh   = (vec >> (w * k)) & mask;
      return PRIO_MAX_W'(sh);
   endfunction

endpackage

`default_nettype wire

// File: rtl/vic_prio_tree.sv
// ============================================================================
// Module      : vic_prio_tree
// Description : Combinational max-finder over the eligible lines. Returns the
//               highest-priority eligible line; ties go to the lower index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vic_prio_tree
   import vic_pkg::*;
#(
   parameter int unsigned N_IRQ  = N_IRQ_DEF,
   parameter int unsigned PRIO_W = PRIO_W_DEF
) (
   input  logic [N_IRQ-1:0]        i_elig,
   input  logic [N_IRQ*PRIO_W-1:0] i_prio,
   output logic                    o_valid,
   output logic [ADDR_W-1:0]       o_idx,
   output logic [PRIO_W-1:0]       o_prio
);

   logic                w_valid;
   logic [ADDR_W-1:0]   w_idx;
   logic [PRIO_W-1:0]   w_prio;

   // Scan upward; a later line replaces the best only when strictly higher,
   // so equal priorities keep the lower index.
   always_comb begin
      w_valid = 1'b0;
      w_idx   = ADDR_NONE;
      w_prio  = '0;
      for (int k = 0; k < N_IRQ; k++) begin
         if (i_elig[k] && (!w_valid || (i_prio[PRIO_W*k +: PRIO_W] > w_prio))) begin
            w_valid = 1'b1;
            w_idx   = ADDR_W'(k);
            w_prio  = i_prio[PRIO_W*k +: PRIO_W];
         end
      end
   end

   assign o_valid = w_valid;
   assign o_idx   = w_idx;
   assign o_prio  = w_prio;

endmodule

`default_nettype wire

// File: rtl/vic_prio_arbiter.sv
// ============================================================================
// Module      : vic_prio_arbiter
// Description : VIC priority arbiter. Picks the most urgent pending line,
//               presents its index under a request/ack handshake, pulses a
//               one-hot clear on ack and tracks in-service state until EOI.
//               Optional preemption stack enabled by macro VIC_NESTING_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vic_prio_arbiter
   import vic_pkg::*;
#(
   parameter int unsigned N_IRQ      = N_IRQ_DEF,
   parameter int unsigned PRIO_W     = PRIO_W_DEF,
   parameter int unsigned NEST_DEPTH = 4
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [N_IRQ-1:0]        i_pend,
   input  logic [N_IRQ*PRIO_W-1:0] i_prio,
   input  logic                    i_en,
   input  logic                    i_ack,
   input  logic                    i_eoi,
   output logic                    o_irq,
   output logic [ADDR_W-1:0]       o_irq_addr,
   output logic [N_IRQ-1:0]        o_clr,
   output logic                    o_busy
);

   vic_state_e          state_q, state_d;
   logic [ADDR_W-1:0]   win_idx_q;
   logic [PRIO_W-1:0]   win_prio_q;
   logic [ADDR_W-1:0]   cur_idx_q;
   logic [PRIO_W-1:0]   cur_prio_q;
   logic                busy_q;
   logic [N_IRQ-1:0]    clr_q;

   logic [PRIO_VEC_MAX-1:0] w_prio_vec;
   logic [N_IRQ-1:0]        w_elig;
   logic                    w_valid;
   logic [ADDR_W-1:0]       w_idx;
   logic [PRIO_W-1:0]       w_prio;
   vic_state_e              w_fallback;

   assign w_prio_vec = PRIO_VEC_MAX'(i_prio);

   // A line competes only if unmasked and more urgent than the work in service
   genvar k;
   generate
      for (k = 0; k < N_IRQ; k++) begin : g_elig
         logic [PRIO_W-1:0] w_prio_k;
         assign w_prio_k  = PRIO_W'(prio_field(w_prio_vec, k, PRIO_W));
         assign w_elig[k] = i_pend[k] && (w_prio_k != '0) && (w_prio_k > cur_prio_q);
      end
   endgenerate

   vic_prio_tree #(
      .N_IRQ  (N_IRQ),
      .PRIO_W (PRIO_W)
   ) u_tree (
      .i_elig  (w_elig),
      .i_prio  (i_prio),
      .o_valid (w_valid),
      .o_idx   (w_idx),
      .o_prio  (w_prio)
   );

   // Abandoning a request returns to the interrupted context if there is one
   assign w_fallback = busy_q ? SERVICE : IDLE;

`ifdef VIC_NESTING_EN
   localparam int unsigned SP_W   = $clog2(NEST_DEPTH + 1);
   localparam int unsigned STK_AW = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;

   logic [SP_W-1:0]   sp_q;
   logic [ADDR_W-1:0] stk_idx_q  [NEST_DEPTH];
   logic [PRIO_W-1:0] stk_prio_q [NEST_DEPTH];
   logic              w_stk_empty;
   logic              w_stk_full;
   logic [STK_AW-1:0] w_push_ptr;
   logic [STK_AW-1:0] w_pop_ptr;

   assign w_stk_empty = (sp_q == '0);
   assign w_stk_full  = (sp_q >= SP_W'(NEST_DEPTH));
   assign w_push_ptr  = STK_AW'(sp_q);
   assign w_pop_ptr   = STK_AW'(sp_q - SP_W'(1));

   // Preempted context is saved when the new winner is acknowledged
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sp_q <= '0;
      end else if ((state_q == REQ) && i_ack && busy_q) begin
         stk_idx_q[w_push_ptr]  <= cur_idx_q;
         stk_prio_q[w_push_ptr] <= cur_prio_q;
         sp_q                   <= sp_q + SP_W'(1);
      end else if ((state_q == SERVICE) && i_eoi && !w_stk_empty) begin
         sp_q <= sp_q - SP_W'(1);
      end
   end
`else
   logic [31:0] w_nest_depth_unused;
   assign w_nest_depth_unused = 32'(NEST_DEPTH);
`endif

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; ack beats a falling enable in REQ
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (i_en && w_valid) state_d = ARB;
         end
         ARB: begin
            if (!i_en || !w_valid) state_d = w_fallback;
            else                   state_d = REQ;
         end
         REQ: begin
            if (i_ack)      state_d = SERVICE;
            else if (!i_en) state_d = w_fallback;
         end
         SERVICE: begin
`ifdef VIC_NESTING_EN
            if (i_eoi)                                 state_d = w_stk_empty ? IDLE : SERVICE;
            else if (i_en && w_valid && !w_stk_full)   state_d = ARB;
`else
            if (i_eoi) state_d = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // Winner latch, in-service context and one-shot clear pulse
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         win_idx_q  <= ADDR_NONE;
         win_prio_q <= '0;
         cur_idx_q  <= ADDR_NONE;
         cur_prio_q <= '0;
         busy_q     <= 1'b0;
         clr_q      <= '0;
      end else begin
         clr_q <= '0;
         if (state_q == ARB) begin
            win_idx_q  <= w_idx;
            win_prio_q <= w_prio;
         end
         if ((state_q == REQ) && i_ack) begin
            clr_q      <= N_IRQ'(1) << win_idx_q;
            cur_idx_q  <= win_idx_q;
            cur_prio_q <= win_prio_q;
            busy_q     <= 1'b1;
         end
         if ((state_q == SERVICE) && i_eoi) begin
`ifdef VIC_NESTING_EN
            if (!w_stk_empty) begin
               cur_idx_q  <= stk_idx_q[w_pop_ptr];
               cur_prio_q <= stk_prio_q[w_pop_ptr];
            end else begin
               cur_idx_q  <= ADDR_NONE;
               cur_prio_q <= '0;
               busy_q     <= 1'b0;
            end
`else
            cur_idx_q  <= ADDR_NONE;
            cur_prio_q <= '0;
            busy_q     <= 1'b0;
`endif
         end
      end
   end

   // Output decode from state and context registers
   always_comb begin
      o_irq      = (state_q == REQ);
      o_irq_addr = ADDR_NONE;
      if (state_q == REQ)          o_irq_addr = win_idx_q;
      else if (state_q == SERVICE) o_irq_addr = cur_idx_q;
      o_clr      = clr_q;
      o_busy     = busy_q;
   end

endmodule

`default_nettype wire
